// File: rtl/window3x3_gen_pkg.sv
// ---------------------------------------------------------------------------
// window3x3_gen_pkg
// Shared definitions for the image-processing blocks (window generator,
// dark-channel and atmospheric-light stages): default pixel width, default
// frame geometry and the pixel type.
// ---------------------------------------------------------------------------
package window3x3_gen_pkg;

    localparam int DW        = 8;
    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;

    typedef logic [DW-1:0] pixel_t;

endpackage : window3x3_gen_pkg

// File: rtl/window3x3_gen_line_buffer.sv
// ---------------------------------------------------------------------------
// line_buffer
// One-line pixel store. One write and one read per cycle at a common address.
// The read is combinational, so during a write it returns the value stored by
// the previous line at that column (read-before-write). Contents carry no
// reset; every location is overwritten before it is consumed.
//
// Ports
//   clock  in  1      rising-edge clock
//   we     in  1      write enable
//   addr   in  AW     shared read/write column address
//   wdata  in  WIDTH  data to store
//   rdata  out WIDTH  data currently stored at addr
// ---------------------------------------------------------------------------
module line_buffer #(
    parameter  int DEPTH = 640,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Read the old value at the column being written this cycle.
    assign rdata = mem_q[addr];

    // Storage write on accepted pixels only.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule : line_buffer

// File: rtl/window3x3_gen.sv
// ---------------------------------------------------------------------------
// window3x3_gen
// Builds a sliding 3x3 pixel window from a raster-order pixel stream using two
// line buffers. A window is flagged valid one cycle after a pixel at
// row >= 2, col >= 2 is accepted; no border padding.
//
// Ports
//   clock       in  1   rising-edge clock
//   reset       in  1   synchronous active-high reset (priority over pix_valid)
//   pix_in      in  DW  raster-order pixel
//   pix_valid   in  1   pix_in accepted this cycle
//   r1..r9      out DW  window: r1..r3 top (oldest line), r7..r9 bottom,
//                       leftmost = oldest column, r9 = newest pixel
//   win_valid   out 1   r1..r9 hold a complete in-image window
//   frame_done  out 1   pulse with the window whose r9 is the last pixel
// ---------------------------------------------------------------------------
module window3x3_gen #(
    parameter int IMG_W = window3x3_gen_pkg::IMG_W_DEF,
    parameter int IMG_H = window3x3_gen_pkg::IMG_H_DEF,
    parameter int DW    = window3x3_gen_pkg::DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] pix_in,
    input  logic          pix_valid,
    output logic [DW-1:0] r1,
    output logic [DW-1:0] r2,
    output logic [DW-1:0] r3,
    output logic [DW-1:0] r4,
    output logic [DW-1:0] r5,
    output logic [DW-1:0] r6,
    output logic [DW-1:0] r7,
    output logic [DW-1:0] r8,
    output logic [DW-1:0] r9,
    output logic          win_valid,
    output logic          frame_done
);

    localparam int            CW       = $clog2(IMG_W);
    localparam int            RW       = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [DW-1:0] win_q [9];
    logic [DW-1:0] win_d [9];
    logic          win_valid_q, win_valid_d;
    logic          frame_done_q, frame_done_d;

    logic          accept_s;
    logic [DW-1:0] one_above_s;
    logic [DW-1:0] two_above_s;

    // Reset wins over an incoming pixel, so it must not disturb the buffers.
    assign accept_s = pix_valid & ~reset;

    // Line 1 holds the previous line; its old value cascades into line 2.
    line_buffer #(.DEPTH(IMG_W), .WIDTH(DW)) u_lb_one (
        .clock (clock),
        .we    (accept_s),
        .addr  (col_q),
        .wdata (pix_in),
        .rdata (one_above_s)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(DW)) u_lb_two (
        .clock (clock),
        .we    (accept_s),
        .addr  (col_q),
        .wdata (one_above_s),
        .rdata (two_above_s)
    );

    // Next-state: raster counters, window shift and valid/done flags.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        if (pix_valid) begin
            // Shift left one column, new right column enters at r3/r6/r9.
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = two_above_s;
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = one_above_s;
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = pix_in;

            // col >= 2 also suppresses windows straddling a line wrap.
            win_valid_d  = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
            frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);

            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '{default: '0};
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign r1         = win_q[0];
    assign r2         = win_q[1];
    assign r3         = win_q[2];
    assign r4         = win_q[3];
    assign r5         = win_q[4];
    assign r6         = win_q[5];
    assign r7         = win_q[6];
    assign r8         = win_q[7];
    assign r9         = win_q[8];
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

endmodule : window3x3_gen
